// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf.sv
// Free-running 32-bit wrapping counters of stall and flush cycles for the
// hazard controller; instantiated only when HAZARD_PERF_EN is defined.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
    end else begin
      if (stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush) perf_flushes      <= perf_flushes + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-BEQ flushes, dmem wait freeze with timeout. HAZARD_PERF_EN adds perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_beq_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flushes
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q;
  logic             mem_wait;
  logic             load_use;

  assign mem_wait = dmem_req & ~dmem_ready;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | (state_d == S_ERROR);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d    = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Priority: reset bubbles > error/mem freeze > branch flush > load-use stall.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state_q == S_ERROR) || mem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (ex_beq_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk               (clk),
    .reset             (reset),
    .stall             (~pc_write),
    .flush             (if_id_flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expected controls.
module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_beq_taken, dmem_req, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic       mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  int pass_cnt;
  int total_cnt;

  // Packed order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, timeout
  localparam logic [6:0] O_RST    = 7'b1111110;
  localparam logic [6:0] O_NORM   = 7'b1101010;
  localparam logic [6:0] O_STALL  = 7'b0001110;
  localparam logic [6:0] O_FLUSH  = 7'b1111110;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_ERROR  = 7'b0000001;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_beq_taken (ex_beq_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
            ex_mem_write, mem_timeout};
  endfunction

  // Drive one cycle of inputs at the falling edge and check the combinational controls.
  task automatic vec(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                     input logic beq, input logic req, input logic rdy, input logic [6:0] exp);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_beq_taken = beq; dmem_req = req; dmem_ready = rdy;
    #1;
    check(tag, 32'(outs()), 32'(exp));
  endtask

  task automatic check_state(input string tag, input hz_state_e st, input int cnt);
    @(posedge clk);
    #1;
    check({tag, "_st"}, 32'(dut.state_q), 32'(st));
    check({tag, "_cnt"}, 32'(dut.wait_cnt_q), 32'(cnt));
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_beq_taken = 0;
    dmem_req = 0; dmem_ready = 0;
    #1;
    check("rst_outs", 32'(outs()), 32'(O_RST));
    check("rst_state", 32'(dut.state_q), 32'(S_RUN));
    @(negedge clk);
    reset = 1'b0;

    vec("normal",       5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, O_NORM);
    vec("lu_rs1",       5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 0, O_STALL);
    vec("lu_released",  5'd5, 5'd2, 1, 0, 5'd5, 0, 0, 0, 0, O_NORM);
    vec("lu_rs2",       5'd1, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0, O_STALL);
    vec("lu_x0",        5'd0, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0, O_NORM);
    vec("lu_nouse",     5'd5, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0, O_NORM);
    vec("lu_diff_rd",   5'd5, 5'd6, 1, 1, 5'd7, 1, 0, 0, 0, O_NORM);
    vec("beq_lu",       5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 0, 0, O_FLUSH);
    vec("beq_only",     5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 0, O_FLUSH);
    vec("rdy_noreq",    5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, O_NORM);
    check_state("rdy_noreq", S_RUN, 0);

    // Three-cycle dmem wait, with a taken branch ignored while frozen.
    vec("mw1",          5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0, O_FREEZE);
    check_state("mw1", S_MEM_WAIT, 1);
    vec("mw2_beq",      5'd5, 5'd2, 1, 0, 5'd5, 1, 1, 1, 0, O_FREEZE);
    vec("mw3",          5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0, O_FREEZE);
    vec("mw_done",      5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 1, O_NORM);
    check_state("mw_done", S_RUN, 0);

    // Asynchronous reset while waiting with wait_cnt == 7.
    for (int i = 0; i < 7; i++)
      vec("rw_freeze", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0, O_FREEZE);
    check_state("rw7", S_MEM_WAIT, 7);
    #2;
    reset = 1'b1;
    #1;
    check("rw_async_st", 32'(dut.state_q), 32'(S_RUN));
    check("rw_async_cnt", 32'(dut.wait_cnt_q), 32'd0);
    check("rw_async_to", 32'(mem_timeout), 32'd0);
`ifdef HAZARD_PERF_EN
    check("rw_perf_stall", perf_stall_cycles, 32'd0);
    check("rw_perf_flush", perf_flushes, 32'd0);
`endif
    dmem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Timeout: 16 waiting cycles reach S_ERROR.
    for (int i = 1; i <= 15; i++)
      vec("to_freeze", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0, O_FREEZE);
    check_state("to15", S_MEM_WAIT, 15);
    vec("to_16th", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0, O_FREEZE);
    @(posedge clk);
    #1;
    check("to_flag", 32'(outs()), 32'(O_ERROR));
    check("to_state", 32'(dut.state_q), 32'(S_ERROR));
    vec("err_sticky", 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1, O_ERROR);
    vec("err_lu",     5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 0, O_ERROR);
    #2;
    reset = 1'b1;
    #1;
    check("err_reset", 32'(outs()), 32'(O_RST));
    @(negedge clk);
    reset = 1'b0;
    vec("post_err", 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 0, O_NORM);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
